// File: rtl/i2s_rx_fifo.sv
// rtl/i2s_rx_fifo.sv - I2S master receiver packing one channel into a FWFT sample FIFO
//
// Ports:
//   HCLK, HRESETn     system clock, asynchronous active-low reset
//   en                link enable; low stops SCK/WS and discards a partial sample
//   chan_sel          0 = capture left slot, 1 = right slot (latched at slot start)
//   SCK, WS, SD       I2S bit clock, word select (driven), serial data (captured)
//   s_valid, s_data   head-of-FIFO sample stream, popped by s_ready
//   level, irq        FIFO occupancy and level >= THRESH interrupt
//   overrun, clr_ovr  sticky dropped-sample flag and its clear
module i2s_rx_fifo #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int THRESH     = 4
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          en,
  input  logic                          chan_sel,
  output logic                          SCK,
  output logic                          WS,
  input  logic                          SD,
  output logic                          s_valid,
  output logic [DATA_W-1:0]             s_data,
  input  logic                          s_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          irq,
  output logic                          overrun,
  input  logic                          clr_ovr
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;

  // Link side
  logic [DIV_W-1:0]  div_cnt;
  logic [5:0]        bit_cnt;
  logic [5:0]        bit_cnt_nxt;
  logic [4:0]        r_idx;
  logic              cap_chan;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_nxt;
  logic [DATA_W-1:0] push_data;
  logic              push_pend;
  logic              tick;
  logic              rise;
  logic              fall;
  logic              cap_bit;

  // FIFO side
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_nxt;
  logic              pop;
  logic              full;
  logic              do_push;

  assign tick        = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise        = en & tick & ~SCK;
  assign fall        = en & tick & SCK;
  assign bit_cnt_nxt = bit_cnt + 6'd1;
  // bit_cnt advances on falls, so at a rise its low bits are the rise index within the slot
  assign r_idx       = bit_cnt[4:0];
  // r=0 carries the previous slot's LSB (one-bit delay); bits past DATA_W are padding
  assign cap_bit     = rise & (WS == cap_chan) & (r_idx != 5'd0) & (r_idx <= 5'(DATA_W));
  assign shift_nxt   = (shift_reg << 1) | DATA_W'(SD);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_cnt   <= '0;
      SCK       <= 1'b0;
      bit_cnt   <= '0;
      WS        <= 1'b0;
      cap_chan  <= 1'b0;
      shift_reg <= '0;
      push_data <= '0;
      push_pend <= 1'b0;
    end else if (!en) begin
      div_cnt   <= '0;
      SCK       <= 1'b0;
      bit_cnt   <= '0;
      WS        <= 1'b0;
      // restart always begins a left slot, so keep the slot selection current while idle
      cap_chan  <= chan_sel;
      shift_reg <= '0;
      push_pend <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      if (tick) begin
        div_cnt <= '0;
        SCK     <= ~SCK;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (fall) begin
        bit_cnt <= bit_cnt_nxt;
        WS      <= bit_cnt_nxt[5];
        if (bit_cnt_nxt[4:0] == 5'd0) begin
          cap_chan <= chan_sel;
        end
      end
      if (cap_bit) begin
        shift_reg <= shift_nxt;
        // the completed sample is held separately so an en drop cannot corrupt it
        if (r_idx == 5'(DATA_W)) begin
          push_pend <= 1'b1;
          push_data <= shift_nxt;
        end
      end
    end
  end

  assign s_valid = (level != '0);
  assign pop     = s_valid & s_ready;
  assign full    = (level == LW'(FIFO_DEPTH));
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push = push_pend & (~full | pop);
  assign s_data  = s_valid ? mem[rd_ptr] : '0;

  always_comb begin
    level_nxt = level;
    if (do_push && !pop) begin
      level_nxt = level + LW'(1);
    end else if (pop && !do_push) begin
      level_nxt = level - LW'(1);
    end
  end

  always_ff @(posedge HCLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      irq     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_nxt;
      irq   <= (level_nxt >= LW'(THRESH));
      // a new drop outranks a clear in the same cycle
      if (push_pend && full && !pop) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// tb/tb_i2s_rx_fifo.sv - directed self-checking bench for i2s_rx_fifo
module tb_i2s_rx_fifo;

  localparam int DATA_W = 24;

  logic              HCLK;
  logic              HRESETn;
  logic              en;
  logic              chan_sel;
  logic              SCK;
  logic              WS;
  logic              SD;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [3:0]        level;
  logic              irq;
  logic              overrun;
  logic              clr_ovr;

  int vec = 0;
  int err = 0;
  int cyc = 0;
  int en_t = 0;
  logic [DATA_W-1:0] left_word;
  logic [DATA_W-1:0] right_word;

  i2s_rx_fifo #(.CLK_DIV(4), .DATA_W(DATA_W), .FIFO_DEPTH(8), .THRESH(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .en(en), .chan_sel(chan_sel),
    .SCK(SCK), .WS(WS), .SD(SD),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .level(level), .irq(irq), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    forever begin
      @(posedge HCLK);
      cyc++;
    end
  end

  // Microphone: counts SCK falls since the last WS change; bit 1 after the change is the MSB.
  // Padding and the delay bit are driven high so any capture of them shows up in the data.
  initial begin : mic
    int bitpos;
    logic sck_prev;
    logic ws_prev;
    logic [DATA_W-1:0] w;
    bitpos = 0;
    sck_prev = 1'b0;
    ws_prev = 1'b0;
    SD = 1'b0;
    forever begin
      @(negedge HCLK);
      if (!en || !HRESETn) begin
        bitpos = 0;
        sck_prev = 1'b0;
        ws_prev = 1'b0;
      end else begin
        if (sck_prev && !SCK) begin
          if (WS !== ws_prev) bitpos = 0;
          else bitpos++;
          ws_prev = WS;
        end
        sck_prev = SCK;
      end
      w = WS ? right_word : left_word;
      if (bitpos >= 1 && bitpos <= DATA_W) SD = w[DATA_W-bitpos];
      else SD = 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] wv(input int k);
    return 24'h3C5A00 + 24'(k) * 24'h010101;
  endfunction

  task automatic test_reset;
    HRESETn = 1'b1;
    en = 1'b0;
    #1;
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    vec++;
    if (SCK !== 1'b0 || WS !== 1'b0 || s_valid !== 1'b0 || level !== 4'd0 || irq !== 1'b0 || overrun !== 1'b0) begin
      err++;
      $display("FAIL reset_held: SCK=%b WS=%b s_valid=%b level=%0d irq=%b overrun=%b, want all 0", SCK, WS, s_valid, level, irq, overrun);
    end
    HRESETn = 1'b1;
    repeat (100) @(negedge HCLK);
    vec++;
    if (SCK !== 1'b0 || WS !== 1'b0) begin
      err++;
      $display("FAIL idle_link: SCK=%b WS=%b, want 0 0", SCK, WS);
    end
    vec++;
    if (s_valid !== 1'b0 || level !== 4'd0 || s_data !== 24'h0) begin
      err++;
      $display("FAIL idle_fifo: s_valid=%b level=%0d s_data=%h, want 0 0 000000", s_valid, level, s_data);
    end
    vec++;
    if (irq !== 1'b0 || overrun !== 1'b0) begin
      err++;
      $display("FAIL idle_flags: irq=%b overrun=%b, want 0 0", irq, overrun);
    end
  endtask

  task automatic test_left_capture;
    int n_valid, last_v, sck_r1, sck_r2, ws_r1, ws_r2;
    logic sck_p, ws_p, v_p;
    chan_sel = 1'b0;
    s_ready = 1'b1;
    left_word = 24'hA5F00F;
    right_word = 24'h123456;
    @(negedge HCLK);
    en = 1'b1;
    n_valid = 0; last_v = 0; sck_r1 = -1; sck_r2 = -1; ws_r1 = -1; ws_r2 = -1;
    sck_p = 1'b0; ws_p = 1'b0; v_p = 1'b0;
    for (int i = 1; i <= 1800; i++) begin
      @(negedge HCLK);
      if (SCK && !sck_p) begin
        if (sck_r1 < 0) sck_r1 = i;
        else if (sck_r2 < 0) sck_r2 = i;
      end
      if (WS && !ws_p) begin
        if (ws_r1 < 0) ws_r1 = i;
        else if (ws_r2 < 0) ws_r2 = i;
      end
      if (s_valid) begin
        vec++;
        if (s_data !== 24'hA5F00F) begin
          err++;
          $display("FAIL left_data: got %h at cycle %0d, want a5f00f", s_data, i);
        end
        vec++;
        if (v_p) begin
          err++;
          $display("FAIL left_pulse: s_valid high 2 cycles at %0d, want 1-cycle pulse", i);
        end
        vec++;
        if (n_valid == 0 && i != 197) begin
          err++;
          $display("FAIL left_latency: first sample at cycle %0d, want 197", i);
        end else if (n_valid != 0 && i - last_v != 512) begin
          err++;
          $display("FAIL left_interval: %0d cycles between samples, want 512", i - last_v);
        end
        n_valid++;
        last_v = i;
      end
      sck_p = SCK; ws_p = WS; v_p = s_valid;
    end
    vec++;
    if (n_valid != 4) begin
      err++;
      $display("FAIL left_count: %0d samples, want 4", n_valid);
    end
    vec++;
    if (sck_r1 != 4 || sck_r2 - sck_r1 != 8) begin
      err++;
      $display("FAIL sck_timing: first rise %0d period %0d, want 4 and 8", sck_r1, sck_r2 - sck_r1);
    end
    vec++;
    if (ws_r1 != 256 || ws_r2 - ws_r1 != 512) begin
      err++;
      $display("FAIL ws_timing: first rise %0d period %0d, want 256 and 512", ws_r1, ws_r2 - ws_r1);
    end
    en = 1'b0;
    s_ready = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic test_right_capture;
    int n_valid, last_v;
    chan_sel = 1'b1;
    s_ready = 1'b1;
    repeat (2) @(negedge HCLK);
    en = 1'b1;
    n_valid = 0; last_v = 0;
    for (int i = 1; i <= 1500; i++) begin
      @(negedge HCLK);
      if (s_valid) begin
        vec++;
        if (s_data !== 24'h123456) begin
          err++;
          $display("FAIL right_data: got %h at cycle %0d, want 123456", s_data, i);
        end
        vec++;
        if ((n_valid == 0 && i != 453) || (n_valid != 0 && i - last_v != 512)) begin
          err++;
          $display("FAIL right_timing: sample %0d at cycle %0d (prev %0d), want 453 then +512", n_valid, i, last_v);
        end
        n_valid++;
        last_v = i;
      end
    end
    vec++;
    if (n_valid != 3) begin
      err++;
      $display("FAIL right_count: %0d samples, want 3", n_valid);
    end
    en = 1'b0;
    s_ready = 1'b0;
    chan_sel = 1'b0;
    repeat (2) @(negedge HCLK);
  endtask

  task automatic test_threshold_overrun;
    logic got;
    logic exp_irq;
    left_word = wv(0);
    s_ready = 1'b0;
    @(negedge HCLK);
    en = 1'b1;
    en_t = cyc;
    for (int k = 0; k < 8; k++) begin
      got = 1'b0;
      for (int i = 0; i < 700 && !got; i++) begin
        @(negedge HCLK);
        if (int'(level) == k + 1) got = 1'b1;
      end
      vec++;
      if (!got) begin
        err++;
        $display("FAIL fill_level: level %0d, want %0d within 700 cycles", level, k + 1);
      end
      exp_irq = (k + 1 >= 4);
      vec++;
      if (irq !== exp_irq) begin
        err++;
        $display("FAIL fill_irq: irq=%b at level %0d, want %b", irq, k + 1, exp_irq);
      end
      left_word = wv(k + 1);
    end
    vec++;
    if (s_data !== wv(0)) begin
      err++;
      $display("FAIL fill_head: s_data=%h, want %h", s_data, wv(0));
    end
    got = 1'b0;
    for (int i = 0; i < 700 && !got; i++) begin
      @(negedge HCLK);
      if (overrun === 1'b1) got = 1'b1;
    end
    vec++;
    if (!got || cyc - en_t != 4293) begin
      err++;
      $display("FAIL overrun_set: overrun=%b at cycle %0d, want 1 at 4293", overrun, cyc - en_t);
    end
    vec++;
    if (level !== 4'd8 || s_data !== wv(0)) begin
      err++;
      $display("FAIL overrun_hold: level=%0d head=%h, want 8 %h", level, s_data, wv(0));
    end
    left_word = wv(9);
    clr_ovr = 1'b1;
    @(negedge HCLK);
    clr_ovr = 1'b0;
    @(negedge HCLK);
    vec++;
    if (overrun !== 1'b0 || level !== 4'd8 || irq !== 1'b1) begin
      err++;
      $display("FAIL clr_ovr: overrun=%b level=%0d irq=%b, want 0 8 1", overrun, level, irq);
    end
  endtask

  task automatic test_full_simul_pop;
    int target;
    target = en_t + 4804;
    for (int i = 0; i < 1000 && cyc < target; i++) @(negedge HCLK);
    vec++;
    if (cyc != target || level !== 4'd8) begin
      err++;
      $display("FAIL simpop_setup: cycle %0d level %0d, want %0d and 8", cyc, level, target);
    end
    s_ready = 1'b1;
    @(negedge HCLK);
    s_ready = 1'b0;
    vec++;
    if (level !== 4'd8 || overrun !== 1'b0) begin
      err++;
      $display("FAIL simpop_level: level=%0d overrun=%b, want 8 0", level, overrun);
    end
    vec++;
    if (s_data !== wv(1) || irq !== 1'b1) begin
      err++;
      $display("FAIL simpop_head: s_data=%h irq=%b, want %h 1", s_data, irq, wv(1));
    end
    en = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic test_drain;
    logic [DATA_W-1:0] exp_w;
    logic exp_irq;
    int exp_lvl;
    repeat (5) @(negedge HCLK);
    vec++;
    if (level !== 4'd8 || irq !== 1'b1 || SCK !== 1'b0 || WS !== 1'b0) begin
      err++;
      $display("FAIL en_off_retain: level=%0d irq=%b SCK=%b WS=%b, want 8 1 0 0", level, irq, SCK, WS);
    end
    s_ready = 1'b1;
    for (int idx = 0; idx < 8; idx++) begin
      exp_w = (idx < 7) ? wv(idx + 1) : wv(9);
      vec++;
      if (s_data !== exp_w) begin
        err++;
        $display("FAIL drain_data: entry %0d got %h, want %h", idx, s_data, exp_w);
      end
      @(negedge HCLK);
      exp_lvl = 7 - idx;
      exp_irq = (exp_lvl >= 4);
      vec++;
      if (int'(level) != exp_lvl || irq !== exp_irq) begin
        err++;
        $display("FAIL drain_level: level=%0d irq=%b, want %0d %b", level, irq, exp_lvl, exp_irq);
      end
    end
    repeat (3) @(negedge HCLK);
    vec++;
    if (s_valid !== 1'b0 || level !== 4'd0) begin
      err++;
      $display("FAIL empty_pop: s_valid=%b level=%0d, want 0 0", s_valid, level);
    end
    s_ready = 1'b0;
  endtask

  task automatic test_en_drop;
    int seen;
    int first_v;
    left_word = 24'h5A0F96;
    @(negedge HCLK);
    en = 1'b1;
    repeat (100) @(negedge HCLK);
    en = 1'b0;
    @(negedge HCLK);
    vec++;
    if (SCK !== 1'b0 || WS !== 1'b0) begin
      err++;
      $display("FAIL en_drop_link: SCK=%b WS=%b, want 0 0", SCK, WS);
    end
    left_word = 24'h96F05A;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge HCLK);
      if (s_valid) seen++;
    end
    vec++;
    if (seen != 0 || level !== 4'd0) begin
      err++;
      $display("FAIL en_drop_push: %0d valid cycles level=%0d, want 0 0", seen, level);
    end
    en = 1'b1;
    first_v = -1;
    for (int i = 1; i <= 400 && first_v < 0; i++) begin
      @(negedge HCLK);
      if (s_valid) first_v = i;
    end
    vec++;
    if (first_v != 197 || s_data !== 24'h96F05A) begin
      err++;
      $display("FAIL en_restart: sample at %0d data %h, want 197 96f05a", first_v, s_data);
    end
    s_ready = 1'b1;
    @(negedge HCLK);
    s_ready = 1'b0;
    en = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic test_reset_mid_frame;
    int seen;
    int first_v;
    left_word = 24'h0FF0A5;
    @(negedge HCLK);
    en = 1'b1;
    repeat (302) @(negedge HCLK);
    vec++;
    if (SCK !== 1'b1 || WS !== 1'b1 || level !== 4'd1) begin
      err++;
      $display("FAIL midframe_setup: SCK=%b WS=%b level=%0d, want 1 1 1", SCK, WS, level);
    end
    #2;
    HRESETn = 1'b0;
    #1;
    vec++;
    if (SCK !== 1'b0 || WS !== 1'b0 || level !== 4'd0 || s_valid !== 1'b0 || irq !== 1'b0) begin
      err++;
      $display("FAIL async_reset: SCK=%b WS=%b level=%0d s_valid=%b irq=%b, want all 0", SCK, WS, level, s_valid, irq);
    end
    en = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    seen = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge HCLK);
      if (s_valid) seen++;
    end
    vec++;
    if (seen != 0 || level !== 4'd0 || overrun !== 1'b0) begin
      err++;
      $display("FAIL post_reset_push: %0d valid cycles level=%0d overrun=%b, want 0 0 0", seen, level, overrun);
    end
    en = 1'b1;
    first_v = -1;
    for (int i = 1; i <= 400 && first_v < 0; i++) begin
      @(negedge HCLK);
      if (s_valid) first_v = i;
    end
    vec++;
    if (first_v != 197 || s_data !== 24'h0FF0A5) begin
      err++;
      $display("FAIL post_reset_capture: sample at %0d data %h, want 197 0ff0a5", first_v, s_data);
    end
    en = 1'b0;
  endtask

  initial begin
    HRESETn = 1'b1;
    en = 1'b0;
    chan_sel = 1'b0;
    s_ready = 1'b0;
    clr_ovr = 1'b0;
    left_word = 24'hA5F00F;
    right_word = 24'h123456;
    test_reset;
    test_left_capture;
    test_right_capture;
    test_threshold_overrun;
    test_full_simul_pop;
    test_drain;
    test_en_drop;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
